// File: rtl/arbitro_rr_if.sv
// Request/grant bundle between the requesting units and the round-robin arbiter.
// The master side drives requests and the slave side (the arbiter) drives grants.
interface arbitro_rr_if;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_num;
  logic       available;
  logic       preempt;

  modport master (output req, input grant, grant_num, available, preempt);
  modport slave  (input req, output grant, grant_num, available, preempt);
endinterface

// File: rtl/arbitro_rr.sv
// Registered four-way round-robin arbiter with grant hold and timeout preemption.
// Outputs decode from registers only, so grant changes solely on rising edges.
module arbitro_rr #(
  parameter int unsigned MAX_HOLD = 8
) (
  input logic         clk,
  input logic         rst,
  arbitro_rr_if.slave bus
);

  localparam int unsigned CW = $clog2(MAX_HOLD + 1);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e          state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [1:0]      owner_q, owner_d;
  logic [CW-1:0]   hold_cnt_q, hold_cnt_d;
  logic            preempt_q, preempt_d;
  logic [3:0]      others;
  logic            owner_holds;

  // First set bit of mask scanning upward from start, wrapping modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] mask, input logic [1:0] start);
    logic [1:0] idx;
    rr_pick = start;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (mask[idx]) rr_pick = idx;
    end
  endfunction

  assign others      = bus.req & ~(4'b0001 << owner_q);
  assign owner_holds = bus.req[owner_q];

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    hold_cnt_d = hold_cnt_q;
    preempt_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req != 4'b0000) begin
          state_d    = StBusy;
          owner_d    = rr_pick(bus.req, ptr_q);
          hold_cnt_d = CW'(1);
        end
      end
      StBusy: begin
        if (!owner_holds) begin
          // Release wins over a coincident timeout, so no preempt pulse here.
          ptr_d = owner_q + 2'd1;
          if (others != 4'b0000) begin
            owner_d    = rr_pick(others, ptr_q);
            hold_cnt_d = CW'(1);
          end else begin
            state_d = StIdle;
          end
        end else if (hold_cnt_q == CW'(MAX_HOLD) && others != 4'b0000) begin
          ptr_d      = owner_q + 2'd1;
          owner_d    = rr_pick(others, ptr_q);
          hold_cnt_d = CW'(1);
          preempt_d  = 1'b1;
        end else if (hold_cnt_q != CW'(MAX_HOLD)) begin
          hold_cnt_d = hold_cnt_q + CW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      ptr_q      <= 2'd0;
      owner_q    <= 2'd0;
      hold_cnt_q <= '0;
      preempt_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      hold_cnt_q <= hold_cnt_d;
      preempt_q  <= preempt_d;
    end
  end

  assign bus.grant     = (state_q == StBusy) ? (4'b0001 << owner_q) : 4'b0000;
  assign bus.grant_num = (state_q == StBusy) ? owner_q : 2'd0;
  assign bus.available = (state_q == StBusy);
  assign bus.preempt   = preempt_q;

endmodule

// File: tb/tb_arbitro_rr.sv
// Scoreboarded bench for arbitro_rr: a behavioural model predicts each cycle's outputs,
// a monitor compares them after every rising edge, and directed checks pin key scenarios.
module tb_arbitro_rr;

  localparam int MAX_HOLD = 8;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] n;
    logic       a;
    logic       p;
  } exp_t;

  logic clk;
  logic rst;
  arbitro_rr_if bus ();

  arbitro_rr #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 0;
  exp_t exp_q[$];

  // Behavioural model state: who owns the resource, for how many cycles, and where
  // the round-robin scan starts.
  int m_busy, m_owner, m_ptr, m_held, m_pre;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic int first_from(input logic [3:0] mask, input int start);
    for (int k = 0; k < 4; k++) begin
      if (mask[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0; m_held = 0; m_pre = 0;
  endtask

  task automatic model_step(input logic [3:0] r);
    logic [3:0] oth;
    int         scan_from;
    m_pre     = 0;
    scan_from = m_ptr;
    if (m_busy == 0) begin
      if (r != 4'b0000) begin
        m_owner = first_from(r, scan_from);
        m_busy  = 1;
        m_held  = 1;
      end
    end else begin
      oth          = r;
      oth[m_owner] = 1'b0;
      if (!r[m_owner]) begin
        m_ptr = (m_owner + 1) % 4;
        if (oth != 4'b0000) begin
          m_owner = first_from(oth, scan_from);
          m_held  = 1;
        end else begin
          m_busy = 0;
        end
      end else if (m_held >= MAX_HOLD && oth != 4'b0000) begin
        m_ptr   = (m_owner + 1) % 4;
        m_owner = first_from(oth, scan_from);
        m_held  = 1;
        m_pre   = 1;
      end else if (m_held < MAX_HOLD) begin
        m_held++;
      end
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.g = (m_busy != 0) ? 4'(1 << m_owner) : 4'b0000;
    e.n = (m_busy != 0) ? 2'(m_owner) : 2'd0;
    e.a = (m_busy != 0);
    e.p = (m_pre != 0);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    n_tests++;
    if (act !== req_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req_v, $time);
    end
  endtask

  // Drive one request pattern for one clock edge; returns 2 time units after that edge.
  task automatic cycle(input logic [3:0] r);
    bus.req = r;
    model_step(r);
    exp_q.push_back(model_out());
    @(posedge clk);
    #2;
  endtask

  // Monitor: compare after every edge against the predicted response.
  always @(posedge clk) begin
    exp_t e;
    exp_t got;
    #1;
    if (mon_en) begin
      got = {bus.grant, bus.grant_num, bus.available, bus.preempt};
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard: no expected entry, got %h at %0t", got, $time);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL scoreboard: got g=%b n=%0d a=%b p=%b, expected g=%b n=%0d a=%b p=%b at %0t",
                   got.g, got.n, got.a, got.p, e.g, e.n, e.a, e.p, $time);
        end
      end
      n_tests++;
      if (!((bus.grant == 4'b0000 && bus.grant_num == 2'd0 && !bus.available) ||
            (bus.grant == (4'b0001 << bus.grant_num) && bus.available))) begin
        n_fail++;
        $display("FAIL onehot: grant=%b grant_num=%0d available=%b, expected consistent one-hot at %0t",
                 bus.grant, bus.grant_num, bus.available, $time);
      end
    end
  end

  initial begin
    logic [3:0] r;
    int         len;
    rst     = 1;
    bus.req = 4'b0000;
    model_reset();
    #1;
    check("reset_grant", 32'(bus.grant), 32'h0);
    check("reset_avail", 32'(bus.available), 32'h0);
    check("reset_preempt", 32'(bus.preempt), 32'h0);
    @(posedge clk);
    #2;
    rst    = 0;
    mon_en = 1;

    // Idle with no requests.
    for (int i = 0; i < 3; i++) cycle(4'b0000);
    check("idle_avail", 32'(bus.available), 32'h0);

    // Reset while requester 2 owns the grant.
    cycle(4'b0100);
    cycle(4'b0100);
    check("own2_grant", 32'(bus.grant), 32'h4);
    mon_en = 0;
    rst    = 1;
    #1;
    check("midrst_grant", 32'(bus.grant), 32'h0);
    check("midrst_avail", 32'(bus.available), 32'h0);
    check("midrst_num", 32'(bus.grant_num), 32'h0);
    model_reset();
    bus.req = 4'b0000;
    @(posedge clk);
    #2;
    rst    = 0;
    mon_en = 1;
    cycle(4'b0000);
    cycle(4'b1111);
    check("post_rst_grant", 32'(bus.grant), 32'h1);

    // Rotation: each owner drops its request for one cycle.
    cycle(4'b1110); check("rot_1", 32'(bus.grant), 32'h2);
    cycle(4'b1101); check("rot_2", 32'(bus.grant), 32'h4);
    cycle(4'b1011); check("rot_3", 32'(bus.grant), 32'h8);
    cycle(4'b0111); check("rot_0", 32'(bus.grant), 32'h1);

    // Pointer skip and wrap.
    cycle(4'b0000);
    cycle(4'b1000); check("own3", 32'(bus.grant), 32'h8);
    cycle(4'b0110); check("skip_grant", 32'(bus.grant), 32'h2);
    check("skip_num", 32'(bus.grant_num), 32'h1);
    cycle(4'b0000);
    cycle(4'b0101); check("wrap_grant", 32'(bus.grant), 32'h4);

    // Timeout preemption with constant contention.
    cycle(4'b0000);
    for (int i = 0; i < MAX_HOLD; i++) begin
      cycle(4'b0011);
      check("to_hold0", 32'({bus.grant, bus.preempt}), 32'({4'b0001, 1'b0}));
    end
    cycle(4'b0011);
    check("to_pre1", 32'({bus.grant, bus.preempt}), 32'({4'b0010, 1'b1}));
    for (int i = 1; i < MAX_HOLD; i++) begin
      cycle(4'b0011);
      check("to_hold1", 32'({bus.grant, bus.preempt}), 32'({4'b0010, 1'b0}));
    end
    cycle(4'b0011);
    check("to_pre0", 32'({bus.grant, bus.preempt}), 32'({4'b0001, 1'b1}));

    // Uncontended hold never times out.
    cycle(4'b0000);
    cycle(4'b0000);
    for (int i = 0; i < 20; i++) begin
      cycle(4'b0100);
      check("unc_hold", 32'({bus.grant, bus.preempt}), 32'({4'b0100, 1'b0}));
    end
    cycle(4'b0000);
    check("unc_release", 32'({bus.grant, bus.available}), 32'h0);

    // Release on the same edge as the timeout: plain release, no preempt.
    for (int i = 0; i < MAX_HOLD; i++) cycle(4'b0011);
    check("coinc_before", 32'(bus.grant), 32'h1);
    cycle(4'b0010);
    check("coinc_after", 32'({bus.grant, bus.preempt}), 32'({4'b0010, 1'b0}));

    // Randomised segments held for variable lengths so timeouts also occur.
    for (int s = 0; s < 60; s++) begin
      r   = 4'($urandom_range(0, 15));
      len = int'($urandom_range(1, 12));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 7) == 0) r[$urandom_range(0, 3)] = ~r[$urandom_range(0, 3)];
        cycle(r);
      end
    end
    cycle(4'b0000);

    mon_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/arbitro_rr.md
# arbitro_rr

Registered four-way round-robin arbiter with grant hold and timeout preemption. It is the sequential successor to the combinational fixed-priority arbiter: same `req`/`grant`/`grant_num`/`available` port family, but it keeps a grant stable while the owner holds its request, and it rotates priority for fairness. It also forcibly reclaims the resource from an owner that holds it longer than `MAX_HOLD` cycles while others wait. It sits between the requesting units and the shared resource; `grant` drives the resource's select/mux directly.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive grant cycles for one owner while another request is pending; legal range 2..255.
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst`  input  1  reset; asynchronous, active-high.
- `req`  input  4  request per requester; the requester holds it high for as long as it needs the resource.
- `grant`  output  4  one-hot grant (registered), or all-zero.
- `grant_num`  output  2  binary index of the granted requester; 0 when `grant` is zero.
- `available`  output  1  high when a grant is active (equals `|grant`).
- `preempt`  output  1  one-cycle pulse, high in the first cycle of a grant that was taken by timeout.

## Operation
- State: FSM {IDLE, BUSY}; `ptr` (2 bits, highest-priority index); `owner` (2 bits); `hold_cnt` (width $clog2(MAX_HOLD+1), saturating).
- Winner selection (combinational, inside block): first asserted `req[i]` scanning i = ptr, ptr+1, … modulo 4. When picking a successor during BUSY, the current owner is excluded from the scan.
- IDLE: if `req != 0`, go to BUSY. Set `owner` = winner and `hold_cnt` = 1. If `req == 0`, stay in IDLE.
- BUSY, owner releases (`req[owner]==0`):
  - If another request is pending, switch directly to that winner with no idle cycle. Set `hold_cnt` = 1 and `ptr` = old owner + 1.
  - Otherwise go to IDLE and set `ptr` = old owner + 1.
- BUSY, owner holds and `hold_cnt == MAX_HOLD` with another request pending: preempt. Switch to the successor winner, set `hold_cnt` = 1, `ptr` = old owner + 1, and set `preempt` high for that first cycle.
- BUSY, owner holds, no timeout: keep `owner`. Increment `hold_cnt`, saturating at `MAX_HOLD`. If no other request is pending, the owner keeps the grant indefinitely.
- `ptr` changes only on release or preemption, never during a hold.
- Outputs decode from registers only: `grant` = BUSY ? (1<<owner) : 0; `grant_num` = BUSY ? owner : 0; `available` = BUSY.
- `ptr` arithmetic is 2-bit wrap-around: 3+1 = 0.

## Timing
- Reset (async, any time including mid-grant) sets IDLE, `ptr`=0, `owner`=0, `hold_cnt`=0. Outputs go immediately to `grant`=0000, `grant_num`=0, `available`=0, `preempt`=0.
- The first rising edge after `rst` deasserts may grant.
- Grant latency: `req` high before edge N gives `grant` high after edge N (1 cycle).
- Release latency: `req[owner]` low before edge N clears `grant[owner]` after edge N. A successor grant appears on that same edge.
- Grant is never two-hot, and never changes except on a rising edge.
- Timeout: with contention present from the start, the owner sees exactly `MAX_HOLD` grant cycles, then the grant moves.
- Simultaneous release and timeout: treated as release; `preempt` stays 0.
- Owner drops and re-raises `req` in the same cycle: not visible to the block; it is treated as a continued hold.
- A `req` raised and dropped between edges is never granted.

## Test plan
- Reset mid-grant: owner=2 granted, assert `rst` between edges → `grant`=0000, `available`=0 immediately, before the next edge. After release, `req`=1111 → `grant`=0001 (ptr back to 0).
- Round-robin rotation: `req`=1111, each owner drops `req` for one cycle after 1 grant cycle → grant sequence 0001, 0010, 0100, 1000, 0001, with no idle cycle between grants.
- Pointer skip and wrap: after owner 3 releases, `req`=0110 → `grant`=0010 (`grant_num`=1). Release, then `req`=0101 → `grant`=0100.
- Timeout preemption (`MAX_HOLD`=8): `req`=0011 held constant → `grant`=0001 for exactly 8 cycles, then 0010 with `preempt`=1 for one cycle. Then 0010 holds 8 cycles, then 0001.
- Uncontended hold: `req`=0100 only, held 20 cycles → `grant`=0100 all 20 cycles, `preempt` never asserts. Drop `req` → `grant`=0000, `available`=0 one cycle later.
- Boundary: release coincident with the timeout cycle → successor granted with `preempt`=0. `req`=0000 throughout → `available` stays 0. At every edge check that `grant` is one-hot-or-zero and that `grant_num` matches it.
